// File: rtl/dppm_frame_encoder_pkg.sv
// Shared definitions for the D-PPM transmit encoder.
//  - LED_ON / LED_OFF : LED pad drive levels
//  - state_t          : encoder FSM states ST_IDLE..ST_GAP
//  - max2             : constant helper used to size the interval counter
package dppm_frame_encoder_pkg;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BITS  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dppm_frame_encoder_if.sv
// Framer-to-encoder bus for the D-PPM transmit encoder.
// Handshake: a frame transfers at a rising clock edge where frame_valid and
// frame_ready are both 1; frame_data and msb_first are only looked at on that
// edge. frame_ready is low for the whole frame in flight, so frame_valid is
// simply ignored while the encoder is busy.
//  master : framer side  (drives frame_valid, frame_data, msb_first, abort)
//  slave  : encoder side (drives frame_ready, led, busy, done, dbg_state)
interface dppm_frame_encoder_if #(
    parameter int FRAME_SIZE = 8
) ();
    import dppm_frame_encoder_pkg::*;

    logic                  frame_valid;
    logic                  frame_ready;
    logic [FRAME_SIZE-1:0] frame_data;
    logic                  msb_first;
    logic                  abort;
    logic                  led;
    logic                  busy;
    logic                  done;
    state_t                dbg_state;

    modport master (
        output frame_valid, frame_data, msb_first, abort,
        input  frame_ready, led, busy, done, dbg_state
    );

    modport slave (
        input  frame_valid, frame_data, msb_first, abort,
        output frame_ready, led, busy, done, dbg_state
    );

endinterface

// File: rtl/dppm_frame_encoder_pulse_timer.sv
// dppm_pulse_timer: interval counter for the D-PPM encoder.
// Counts cycles since the most recent pulse rising edge. clear_i forces the
// next value to 0; otherwise the counter increments and saturates (it never
// wraps). Terminal-count flags are true in the cycle whose count equals the
// named interval minus one, i.e. the edge at the end of that cycle is the one
// that lands exactly on the interval.
//  clock, reset  : clock and asynchronous active-high reset
//  clear_i       : restart counting from 0
//  low_tc_o      : INTERVAL_LOW  reached at the next edge
//  high_tc_o     : INTERVAL_HIGH reached at the next edge
//  pulse_end_o   : PULSE_WIDTH   reached at the next edge
//  gap_tc_o      : GAP_CYCLES    reached at the next edge
module dppm_pulse_timer #(
    parameter int CNT_W         = 5,
    parameter int INTERVAL_LOW  = 4,
    parameter int INTERVAL_HIGH = 8,
    parameter int PULSE_WIDTH   = 1,
    parameter int GAP_CYCLES    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    output logic low_tc_o,
    output logic high_tc_o,
    output logic pulse_end_o,
    output logic gap_tc_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign low_tc_o    = (count_q == CNT_W'(INTERVAL_LOW  - 1));
    assign high_tc_o   = (count_q == CNT_W'(INTERVAL_HIGH - 1));
    assign pulse_end_o = (count_q == CNT_W'(PULSE_WIDTH   - 1));
    assign gap_tc_o    = (count_q == CNT_W'(GAP_CYCLES    - 1));

endmodule

// File: rtl/dppm_frame_encoder.sv
// dppm_frame_encoder: D-PPM transmit encoder for the LightIO optical link.
// Accepts a frame from the framer and drives the LED with a start pulse
// followed by one pulse per bit; the spacing between pulse rising edges is
// INTERVAL_LOW for a 0 bit and INTERVAL_HIGH for a 1 bit. After the last bit
// pulse a GAP_CYCLES quiet period runs, then done strobes for one cycle.
//  clock, reset : clock and asynchronous active-high reset
//  bus (slave)  : frame handshake, bit order, abort, LED, busy, done, state
// All bus outputs are registered.
module dppm_frame_encoder
    import dppm_frame_encoder_pkg::*;
#(
    parameter int FRAME_SIZE    = 8,
    parameter int INTERVAL_LOW  = 4,
    parameter int INTERVAL_HIGH = 8,
    parameter int PULSE_WIDTH   = 1,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    dppm_frame_encoder_if.slave  bus
);

    localparam int CNT_W = $clog2(max2(INTERVAL_HIGH, GAP_CYCLES) + 1);
    localparam int BIT_W = $clog2(FRAME_SIZE + 1);

    if (FRAME_SIZE < 1)                 begin : g_bad_size  $error("FRAME_SIZE must be >= 1"); end
    if (PULSE_WIDTH < 1)                begin : g_bad_pw    $error("PULSE_WIDTH must be >= 1"); end
    if (INTERVAL_LOW <= PULSE_WIDTH)    begin : g_bad_low   $error("INTERVAL_LOW must exceed PULSE_WIDTH"); end
    if (INTERVAL_HIGH <= INTERVAL_LOW)  begin : g_bad_high  $error("INTERVAL_HIGH must exceed INTERVAL_LOW"); end
    if (GAP_CYCLES < PULSE_WIDTH)       begin : g_bad_gap   $error("GAP_CYCLES must be >= PULSE_WIDTH"); end

    state_t                state_q, state_d;
    logic [FRAME_SIZE-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  led_q, led_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  low_tc, high_tc, pulse_end, gap_tc;
    logic [FRAME_SIZE-1:0] data_rev;
    logic                  accept, in_bits, ivl_tc, rise, last_bit, abort_hit;

    // MSB-first frames are stored bit-reversed so the shifter always sends bit 0.
    always_comb begin
        data_rev = '0;
        for (int i = 0; i < FRAME_SIZE; i++) begin
            data_rev[i] = bus.frame_data[FRAME_SIZE-1-i];
        end
    end

    assign accept    = bus.frame_valid & ready_q & (state_q == ST_IDLE);
    assign in_bits   = (state_q == ST_START) || (state_q == ST_BITS);
    assign abort_hit = bus.abort && (state_q != ST_IDLE);
    // The interval ending at the next pulse is chosen by the bit being sent.
    assign ivl_tc    = shreg_q[0] ? high_tc : low_tc;
    assign rise      = in_bits && ivl_tc && !bus.abort;
    assign last_bit  = (bit_cnt_q == BIT_W'(FRAME_SIZE - 1));

    dppm_pulse_timer #(
        .CNT_W         (CNT_W),
        .INTERVAL_LOW  (INTERVAL_LOW),
        .INTERVAL_HIGH (INTERVAL_HIGH),
        .PULSE_WIDTH   (PULSE_WIDTH),
        .GAP_CYCLES    (GAP_CYCLES)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (accept || rise || (state_q == ST_IDLE)),
        .low_tc_o    (low_tc),
        .high_tc_o   (high_tc),
        .pulse_end_o (pulse_end),
        .gap_tc_o    (gap_tc)
    );

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            led_q     <= LED_OFF;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            led_q     <= led_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic, including the bit shifter and bit counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shreg_d   = bus.msb_first ? data_rev : bus.frame_data;
                    bit_cnt_d = '0;
                end
            end
            ST_START, ST_BITS: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (ivl_tc) begin
                    state_d   = last_bit ? ST_GAP : ST_BITS;
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (bus.abort || gap_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered-output next values.
    always_comb begin
        led_d = led_q;
        if (accept || rise) begin
            led_d = LED_ON;
        end else if (abort_hit || (state_q != ST_IDLE && pulse_end)) begin
            led_d = LED_OFF;
        end
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_GAP) && gap_tc && !bus.abort;
    end

    assign bus.led         = led_q;
    assign bus.frame_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_dppm_frame_encoder.sv
module tb_dppm_frame_encoder;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // a: FRAME_SIZE=4, LOW=3, HIGH=5, PW=1, GAP=4.  b: same with PW=2.
  dppm_frame_encoder_if #(.FRAME_SIZE(4)) bus_a ();
  dppm_frame_encoder_if #(.FRAME_SIZE(4)) bus_b ();

  dppm_frame_encoder #(
    .FRAME_SIZE(4), .INTERVAL_LOW(3), .INTERVAL_HIGH(5), .PULSE_WIDTH(1), .GAP_CYCLES(4)
  ) dut_a (
    .clock (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  dppm_frame_encoder #(
    .FRAME_SIZE(4), .INTERVAL_LOW(3), .INTERVAL_HIGH(5), .PULSE_WIDTH(2), .GAP_CYCLES(4)
  ) dut_b (
    .clock (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input int c, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  function automatic logic [63:0] pm(input int p0, input int p1, input int p2,
                                     input int p3, input int p4);
    logic [63:0] m;
    m = '0;
    m[p0] = 1'b1; m[p1] = 1'b1; m[p2] = 1'b1; m[p3] = 1'b1; m[p4] = 1'b1;
    return m;
  endfunction

  task automatic check_outputs(input string tag, input int c, input bit use_b,
                               input logic e_led, input logic e_rdy,
                               input logic e_busy, input logic e_done);
    chk({tag, ".led"},   c, use_b ? bus_b.led         : bus_a.led,         e_led);
    chk({tag, ".ready"}, c, use_b ? bus_b.frame_ready : bus_a.frame_ready, e_rdy);
    chk({tag, ".busy"},  c, use_b ? bus_b.busy        : bus_a.busy,        e_busy);
    chk({tag, ".done"},  c, use_b ? bus_b.done        : bus_a.done,        e_done);
  endtask

  // Offers one frame in cycle 0 and checks cycles 0..stop_c. The frame is busy
  // for cycles 1..end_c-1; done strobes at end_c when done_at_end is set.
  task automatic run_frame(input string tag, input bit use_b, input logic [3:0] data,
                           input logic msb, input logic [63:0] mask, input int end_c,
                           input bit done_at_end, input int abort_c, input int stop_c);
    bit in_flight;
    for (int c = 0; c <= stop_c; c++) begin
      if (use_b) begin
        bus_b.frame_valid = (c == 0); bus_b.frame_data = data; bus_b.msb_first = msb;
        bus_b.abort = (c == abort_c);
      end else begin
        bus_a.frame_valid = (c == 0); bus_a.frame_data = data; bus_a.msb_first = msb;
        bus_a.abort = (c == abort_c);
      end
      in_flight = (c >= 1) && (c < end_c);
      check_outputs(tag, c, use_b, mask[c], !in_flight, in_flight,
                    done_at_end && (c == end_c));
      if (c < stop_c) begin
        @(posedge clk); #1;
      end
    end
    bus_a.frame_valid = 1'b0; bus_a.abort = 1'b0;
    bus_b.frame_valid = 1'b0; bus_b.abort = 1'b0;
  endtask

  logic [63:0] m;
  bit          b4;

  initial begin
    bus_a.frame_valid = 1'b0; bus_a.frame_data = '0; bus_a.msb_first = 1'b0; bus_a.abort = 1'b0;
    bus_b.frame_valid = 1'b0; bus_b.frame_data = '0; bus_b.msb_first = 1'b0; bus_b.abort = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_outputs("reset_b", 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // 1: 0110 LSB-first -> intervals 3,5,5,3, pulses 1,4,9,14,17, done 21.
    run_frame("s1_0110_lsb", 1'b0, 4'b0110, 1'b0, pm(1, 4, 9, 14, 17), 21, 1'b1, -1, 22);

    // 2: symmetric data MSB-first, then 0001 in both orders.
    run_frame("s2_0110_msb", 1'b0, 4'b0110, 1'b1, pm(1, 4, 9, 14, 17), 21, 1'b1, -1, 22);
    run_frame("s2_0001_lsb", 1'b0, 4'b0001, 1'b0, pm(1, 6, 9, 12, 15), 19, 1'b1, -1, 20);
    run_frame("s2_0001_msb", 1'b0, 4'b0001, 1'b1, pm(1, 4, 7, 10, 15), 19, 1'b1, -1, 20);

    // 3: PW=2, 0000 -> high 1-2,4-5,7-8,10-11,13-14, done 17.
    m = pm(1, 4, 7, 10, 13);
    m = m | (m << 1);
    run_frame("s3_pw2", 1'b1, 4'b0000, 1'b0, m, 17, 1'b1, -1, 18);

    // 4: frame_valid held; second frame (0001 LSB) accepted in done cycle 21.
    m = pm(1, 4, 9, 14, 17) | pm(22, 27, 30, 33, 36);
    for (int c = 0; c <= 41; c++) begin
      bus_a.frame_valid = (c <= 21);
      bus_a.frame_data  = (c == 0) ? 4'b0110 : 4'b0001;
      bus_a.msb_first   = 1'b0;
      b4 = ((c >= 1) && (c <= 20)) || ((c >= 22) && (c <= 39));
      check_outputs("s4_b2b", c, 1'b0, m[c], !b4, b4, (c == 21) || (c == 40));
      @(posedge clk); #1;
    end
    bus_a.frame_valid = 1'b0;

    // 5: abort during cycle 6 -> idle from cycle 7, no done; next frame normal.
    run_frame("s5_abort", 1'b0, 4'b0110, 1'b0, pm(1, 4, 4, 4, 4), 7, 1'b0, 6, 10);
    run_frame("s5_after", 1'b0, 4'b0110, 1'b0, pm(1, 4, 9, 14, 17), 21, 1'b1, -1, 22);

    // 6: async reset mid-pulse (cycle 10 of 0001 MSB-first), then a fresh frame.
    run_frame("s6_pre", 1'b0, 4'b0001, 1'b1, pm(1, 4, 7, 10, 15), 19, 1'b1, -1, 10);
    #3 reset = 1'b1;
    #1;
    check_outputs("s6_async", 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outputs("s6_held", 11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_frame("s6_after", 1'b0, 4'b0110, 1'b0, pm(1, 4, 9, 14, 17), 21, 1'b1, -1, 22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
